stream_pool_unit: RTL and testbench

//  Streaming WINxWIN pooling (stride = WIN) over an IMG_N x IMG_N unsigned feature map.

---
 rtl/stream_pool_unit.sv | 155 +++++++++++++++
 tb/tb_stream_pool_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_pool_unit.sv
// stream_pool_unit: streaming WINxWIN, stride-WIN average/max pooling of a raster-order pixel stream.
// Define POOL_MAX_EN to build the max datapath (mode selects avg/max); otherwise average only.
module stream_pool_unit #(
  parameter int DATA_W = 16,
  parameter int IMG_N  = 28,
  parameter int WIN    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] pixel_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] pixel_out,
  output logic              finish
);
  localparam int LW    = $clog2(WIN);
  localparam int SH    = 2 * LW;
  localparam int ACC_W = DATA_W + SH;
  localparam int OUT_N = IMG_N / WIN;
  localparam int CW    = (IMG_N > 1) ? $clog2(IMG_N) : 1;
  localparam int IW    = (OUT_N > 1) ? $clog2(OUT_N) : 1;
  localparam int LB_D  = 1 << IW;
  localparam logic [CW-1:0] LAST = CW'(IMG_N - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_col;
  logic [CW-1:0]    r_row;
  logic             r_in_done;
  logic [ACC_W-1:0] r_h_acc;
  logic [ACC_W-1:0] r_lb [LB_D];
  logic             r_out_valid;
  logic [DATA_W-1:0] r_pixel_out;
  logic             r_finish;

  logic             w_take;
  logic             w_col_end;
  logic             w_row_end;
  logic [IW-1:0]    w_lb_idx;
  logic [ACC_W-1:0] w_px;
  logic [ACC_W-1:0] w_lb_cur;
  logic [ACC_W-1:0] w_h_comb;
  logic [ACC_W-1:0] w_h_new;
  logic [ACC_W-1:0] w_v_comb;
  logic [ACC_W-1:0] w_v_new;
  logic [DATA_W-1:0] w_out;

  assign in_ready  = (r_state == S_BUSY) && !(r_out_valid && !out_ready) && !r_in_done;
  assign out_valid = r_out_valid;
  assign pixel_out = r_pixel_out;
  assign finish    = r_finish;

  assign w_take    = in_valid && in_ready;
  assign w_col_end = &r_col[LW-1:0];
  assign w_row_end = &r_row[LW-1:0];
  assign w_lb_idx  = IW'(r_col >> LW);
  assign w_px      = ACC_W'(pixel_in);
  assign w_lb_cur  = r_lb[w_lb_idx];

  // First pixel of a horizontal window seeds h_acc; first row of a window band seeds the line buffer.
  assign w_h_new = (r_col[LW-1:0] == '0) ? w_px : w_h_comb;
  assign w_v_new = (r_row[LW-1:0] == '0) ? w_h_new : w_v_comb;

`ifdef POOL_MAX_EN
  logic r_mode;

  assign w_h_comb = r_mode ? ((r_h_acc > w_px) ? r_h_acc : w_px) : (r_h_acc + w_px);
  assign w_v_comb = r_mode ? ((w_lb_cur > w_h_new) ? w_lb_cur : w_h_new) : (w_lb_cur + w_h_new);
  assign w_out    = r_mode ? w_v_new[DATA_W-1:0] : w_v_new[ACC_W-1:SH];
`else
  logic w_unused_mode;

  assign w_unused_mode = mode;
  assign w_h_comb      = r_h_acc + w_px;
  assign w_v_comb      = w_lb_cur + w_h_new;
  assign w_out         = w_v_new[ACC_W-1:SH];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_in_done   <= 1'b0;
      r_h_acc     <= '0;
      r_out_valid <= 1'b0;
      r_pixel_out <= '0;
      r_finish    <= 1'b0;
`ifdef POOL_MAX_EN
      r_mode      <= 1'b0;
`endif
      for (int unsigned i = 0; i < LB_D; i++) begin
        r_lb[i] <= '0;
      end
    end else begin
      r_finish <= 1'b0;
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_BUSY;
            r_col     <= '0;
            r_row     <= '0;
            r_in_done <= 1'b0;
`ifdef POOL_MAX_EN
            r_mode    <= mode;
`endif
          end
        end
        S_BUSY: begin
          if (w_take) begin
            r_h_acc <= w_h_new;
            if (w_col_end) begin
              r_lb[w_lb_idx] <= w_v_new;
              // A new result can only land when the previous one is gone or leaving this cycle.
              if (w_row_end) begin
                r_out_valid <= 1'b1;
                r_pixel_out <= w_out;
              end
            end
            if (r_col == LAST) begin
              r_col <= '0;
              if (r_row == LAST) begin
                r_row     <= '0;
                r_in_done <= 1'b1;
              end else begin
                r_row <= r_row + CW'(1);
              end
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
          if (r_in_done && r_out_valid && out_ready) begin
            r_state  <= S_DONE;
            r_finish <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_pool_unit.sv
// Directed and randomised checks of stream_pool_unit at IMG_N=4 with WIN=2 and WIN=4.
module tb_stream_pool_unit;
`ifdef POOL_MAX_EN
  localparam bit MAX_EN = 1'b1;
`else
  localparam bit MAX_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, mode, in_valid, out_ready;
  logic        in_ready, out_valid, finish;
  logic [15:0] pixel_in, pixel_out;

  logic        d4_start, d4_mode, d4_in_valid, d4_out_ready;
  logic        d4_in_ready, d4_out_valid, d4_finish;
  logic [15:0] d4_pixel_in, d4_pixel_out;

  always #5 clk = ~clk;

  stream_pool_unit #(.DATA_W(16), .IMG_N(4), .WIN(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .pixel_in(pixel_in),
    .out_valid(out_valid), .out_ready(out_ready), .pixel_out(pixel_out),
    .finish(finish)
  );

  stream_pool_unit #(.DATA_W(16), .IMG_N(4), .WIN(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(d4_start), .mode(d4_mode),
    .in_valid(d4_in_valid), .in_ready(d4_in_ready), .pixel_in(d4_pixel_in),
    .out_valid(d4_out_valid), .out_ready(d4_out_ready), .pixel_out(d4_pixel_out),
    .finish(d4_finish)
  );

  typedef struct {
    logic              mode;
    logic [15:0][15:0] px;
    logic [3:0][15:0]  ex;   // ex[k] = k-th pooled pixel in raster order
  } vec_t;

  int unsigned n_pass = 0;
  int unsigned n_tot  = 0;
  logic [15:0] fr_px [16];
  logic [15:0] ex [4];
  logic [15:0] got [$];
  int          fin_cnt;
  int          taken;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: pool each 2x2 window directly from the whole frame.
  function automatic logic [15:0] ref_pool(input logic m, input int oy, input int ox);
    int unsigned s  = 0;
    logic [15:0] mx = '0;
    for (int dy = 0; dy < 2; dy++) begin
      for (int dx = 0; dx < 2; dx++) begin
        logic [15:0] v;
        v = fr_px[(2 * oy + dy) * 4 + 2 * ox + dx];
        s += v;
        if (v > mx) mx = v;
      end
    end
    return (m && MAX_EN) ? mx : 16'(s >> 2);
  endfunction

  task automatic run_frame(input logic m, input int gap, input int rdy_pct, input bit do_stall);
    int          idx        = 0;
    int          stall_left = 0;
    bit          stalled    = 1'b0;
    bit          done       = 1'b0;
    logic [15:0] held       = '0;
    got.delete();
    fin_cnt = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      start = (c == 0);
      mode  = m;
      if (do_stall && !stalled && out_valid) begin
        stalled    = 1'b1;
        stall_left = 5;
        held       = pixel_out;
      end
      out_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
      in_valid  = (c > 0) && ($urandom_range(0, 99) >= gap);
      pixel_in  = (idx < 16) ? fr_px[idx] : 16'hBEEF;
      #1;
      if (c == 0) check("finish_width", {31'd0, finish}, 32'd0);
      if (stall_left > 0) begin
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        check("stall_hold", {16'd0, pixel_out}, {16'd0, held});
        stall_left--;
      end
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) got.push_back(pixel_out);
      if (finish) begin
        fin_cnt++;
        done = 1'b1;
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    taken    = idx;
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_n_out"}, got.size(), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_px%0d", tag, k),
            (k < got.size()) ? {16'd0, got[k]} : 32'hFFFF_FFFF, {16'd0, ex[k]});
    end
    check({tag, "_finish"}, fin_cnt, 32'd1);
    check({tag, "_taken"}, taken, 32'd16);
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < 16; i++) fr_px[i] = v.px[i];
    for (int k = 0; k < 4; k++) ex[k] = v.ex[k];
  endtask

  initial begin
    vec_t vt [6];
    vec_t ramp;
    int   n;
    int   outs;
    int   fins;

    rst_n = 1'b0;
    {start, mode, in_valid, out_ready, pixel_in} = '0;
    {d4_start, d4_mode, d4_in_valid, d4_out_ready, d4_pixel_in} = '0;

    for (int i = 0; i < 6; i++) vt[i].px = '0;
    for (int i = 0; i < 16; i++) begin
      vt[0].px[i] = 16'(i);
      vt[1].px[i] = 16'(i);
      vt[2].px[i] = 16'hFFFF;
      vt[3].px[i] = 16'(15 - i);
      vt[5].px[i] = 16'd3;
    end
    vt[4].px[5]  = 16'hFFFF;
    vt[4].px[10] = 16'd3;
    vt[4].px[15] = 16'd1;
    vt[5].px[0]  = 16'd0;
    vt[0].mode = 1'b0; vt[0].ex = {16'd12, 16'd10, 16'd4, 16'd2};
    vt[1].mode = 1'b1;
    vt[1].ex   = MAX_EN ? {16'd15, 16'd13, 16'd7, 16'd5} : {16'd12, 16'd10, 16'd4, 16'd2};
    vt[2].mode = 1'b0; vt[2].ex = {4{16'hFFFF}};
    vt[3].mode = 1'b1;
    vt[3].ex   = MAX_EN ? {16'd5, 16'd7, 16'd13, 16'd15} : {16'd2, 16'd4, 16'd10, 16'd12};
    vt[4].mode = 1'b1;
    vt[4].ex   = MAX_EN ? {16'd3, 16'd0, 16'd0, 16'hFFFF} : {16'd1, 16'd0, 16'd0, 16'h3FFF};
    vt[5].mode = 1'b0; vt[5].ex = {16'd3, 16'd3, 16'd3, 16'd2};
    ramp = vt[0];

    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_pixel_out", {16'd0, pixel_out}, 32'd0);
    check("rst_finish", {31'd0, finish}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_w4_out_valid", {31'd0, d4_out_valid}, 32'd0);
    check("rst_w4_in_ready", {31'd0, d4_in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      load_vec(vt[v]);
      run_frame(vt[v].mode, 0, 100, 1'b0);
      check_frame($sformatf("vec%0d", v));
    end

    // WIN=4: one output from sixteen full-scale pixels, sum must not wrap.
    @(negedge clk);
    d4_start = 1'b1;
    @(negedge clk);
    d4_start     = 1'b0;
    d4_out_ready = 1'b1;
    d4_pixel_in  = 16'hFFFF;
    n = 0; outs = 0; fins = 0;
    for (int c = 0; c < 60 && fins == 0; c++) begin
      d4_in_valid = 1'b1;
      #1;
      if (d4_in_valid && d4_in_ready) n++;
      if (d4_out_valid && d4_out_ready) begin
        outs++;
        check("w4_avg", {16'd0, d4_pixel_out}, 32'h0000_FFFF);
      end
      if (d4_finish) fins++;
      @(negedge clk);
    end
    d4_in_valid = 1'b0;
    check("w4_taken", n, 32'd16);
    check("w4_n_out", outs, 32'd1);
    check("w4_finish", fins, 32'd1);

    load_vec(ramp);
    run_frame(1'b0, 0, 100, 1'b1);
    check_frame("stall");

    // Mid-frame start must not restart counters; then an async reset aborts with a pending output.
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      @(negedge clk);
      start     = (c == 0) || (n == 3);
      mode      = 1'b0;
      out_ready = 1'b0;
      in_valid  = (c > 0);
      pixel_in  = fr_px[n];
      #1;
      if (in_valid && in_ready) n++;
    end
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_taken", n, 32'd6);
    check("mid_out_valid", {31'd0, out_valid}, 32'd1);
    check("mid_pixel_out", {16'd0, pixel_out}, 32'd2);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_finish", {31'd0, finish}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    check("abort_pixel_out", {16'd0, pixel_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    load_vec(ramp);
    run_frame(1'b0, 0, 100, 1'b0);
    check_frame("after_rst");

    for (int f = 0; f < 500; f++) begin
      logic m;
      m = 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) begin
        fr_px[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      end
      for (int k = 0; k < 4; k++) ex[k] = ref_pool(m, k / 2, k % 2);
      run_frame(m, $urandom_range(0, 60), $urandom_range(40, 100), 1'b0);
      check_frame($sformatf("rnd%0d", f));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
